// File: rtl/muldiv_pkg.sv
// Shared op encodings, FSM states and op-decode helpers for the iterative
// multiply/divide unit.
package muldiv_pkg;

    typedef enum logic [1:0] {
        MD_OP_MULT  = 2'b00,
        MD_OP_MULTU = 2'b01,
        MD_OP_DIV   = 2'b10,
        MD_OP_DIVU  = 2'b11
    } md_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } md_state_e;

    function automatic logic md_is_div(input logic [1:0] op);
        return op[1];
    endfunction

    function automatic logic md_is_signed(input logic [1:0] op);
        return ~op[0];
    endfunction

endpackage

// File: rtl/muldiv_datapath.sv
// One-bit-per-cycle engine: shift-add multiply or restoring divide on unsigned
// magnitudes. acc holds {hi, lo}; step_o is the accumulator after this cycle.
module muldiv_datapath #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               load,
    input  logic               step,
    input  logic               div_mode,
    input  logic [WIDTH-1:0]   op_a,
    input  logic [WIDTH-1:0]   op_b,
    output logic [2*WIDTH-1:0] step_o
);
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   opnd;
    logic               div_q;
    logic [WIDTH:0]     add_sum;
    logic [WIDTH:0]     trial;
    logic [WIDTH:0]     diff;

    // Multiply keeps the multiplier in acc's low half and adds the multiplicand
    // into the high half; divide shifts the dividend in and subtracts the divisor.
    always_comb begin
        add_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
        trial   = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        diff    = trial - {1'b0, opnd};
        step_o  = acc;
        if (div_q) begin
            if (!diff[WIDTH])
                step_o = {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
            else
                step_o = {trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
        end else begin
            step_o = {add_sum, acc[WIDTH-1:1]};
        end
    end

    always_ff @(posedge clk) begin
        if (load) begin
            div_q <= div_mode;
            acc   <= {{WIDTH{1'b0}}, (div_mode ? op_a : op_b)};
            opnd  <= div_mode ? op_b : op_a;
        end else if (step) begin
            acc <= step_o;
        end
    end

endmodule

// File: rtl/muldiv_iter.sv
// Iterative MULT/MULTU/DIV/DIVU unit with start/done handshake, pipeline stall
// and flush cancellation. Results are returned as HI/LO words.
module muldiv_iter
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic [1:0]       op_i,
    input  logic [WIDTH-1:0] src1_i,
    input  logic [WIDTH-1:0] src2_i,
    input  logic             flush_i,
    output logic             busy_o,
    output logic             stall_o,
    output logic             done_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o,
    output logic             div_zero_o
);
    md_state_e          state_q, state_d;
    logic [CNT_W-1:0]   cnt_q;
    logic               div_q, neg_q_q, neg_r_q, dz_q;
    logic               load, dz_start, calc_step, last_iter, sgn;
    logic [2*WIDTH-1:0] step_res, fixed_res;

    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] x, input logic s);
        logic signed [WIDTH-1:0] xs;
        xs = signed'(x);
        return (s && xs < 0) ? unsigned'(-xs) : x;
    endfunction

    function automatic logic [2*WIDTH-1:0] sign_fix(input logic [2*WIDTH-1:0] raw,
                                                    input logic is_div, input logic nq,
                                                    input logic nr);
        logic [WIDTH-1:0] r, q;
        if (!is_div)
            return nq ? -raw : raw;
        r = raw[2*WIDTH-1:WIDTH];
        q = raw[WIDTH-1:0];
        return {(nr ? -r : r), (nq ? -q : q)};
    endfunction

    assign sgn       = md_is_signed(op_i);
    assign load      = (state_q == ST_IDLE) & start_i & ~flush_i;
    assign dz_start  = load & md_is_div(op_i) & (src2_i == '0);
    assign calc_step = (state_q == ST_CALC) & ~flush_i;
    assign last_iter = cnt_q == CNT_W'(WIDTH - 1);
    assign fixed_res = sign_fix(step_res, div_q, neg_q_q, neg_r_q);

    muldiv_datapath #(.WIDTH(WIDTH)) u_datapath (
        .clk      (clk),
        .load     (load & ~dz_start),
        .step     (calc_step),
        .div_mode (md_is_div(op_i)),
        .op_a     (magnitude(src1_i, sgn)),
        .op_b     (magnitude(src2_i, sgn)),
        .step_o   (step_res)
    );

    always_comb begin
        state_d    = state_q;
        busy_o     = state_q != ST_IDLE;
        done_o     = 1'b0;
        div_zero_o = 1'b0;
        stall_o    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                stall_o = start_i & ~flush_i;
                if (load)
                    state_d = dz_start ? ST_DONE : ST_CALC;
            end
            ST_CALC: begin
                stall_o = 1'b1;
                if (flush_i)
                    state_d = ST_IDLE;
                else if (last_iter)
                    state_d = ST_DONE;
            end
            ST_DONE: begin
                done_o     = ~flush_i;
                div_zero_o = dz_q & ~flush_i;
                state_d    = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            div_q   <= 1'b0;
            neg_q_q <= 1'b0;
            neg_r_q <= 1'b0;
            dz_q    <= 1'b0;
            hi_o    <= '0;
            lo_o    <= '0;
        end else begin
            state_q <= state_d;
            if (load) begin
                div_q   <= md_is_div(op_i);
                neg_q_q <= sgn & (src1_i[WIDTH-1] ^ src2_i[WIDTH-1]);
                neg_r_q <= sgn & src1_i[WIDTH-1];
                dz_q    <= dz_start;
                cnt_q   <= '0;
                if (dz_start) begin
                    hi_o <= src1_i;
                    lo_o <= '1;
                end
            end else if (calc_step) begin
                cnt_q <= last_iter ? '0 : cnt_q + 1'b1;
                if (last_iter)
                    {hi_o, lo_o} <= fixed_res;
            end else if (state_q == ST_CALC) begin
                cnt_q <= '0;
            end
        end
    end

endmodule

// File: tb/tb_muldiv_iter.sv
// Directed bench for muldiv_iter: vector table plus flush/restart/reset sequences.
module tb_muldiv_iter;
    localparam int W = 32;

    logic         clk, rst, start_i, flush_i;
    logic [1:0]   op_i;
    logic [W-1:0] src1_i, src2_i, hi_o, lo_o;
    logic         busy_o, stall_o, done_o, div_zero_o;

    int errors = 0;
    int checks = 0;

    muldiv_iter #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .start_i(start_i), .op_i(op_i),
        .src1_i(src1_i), .src2_i(src2_i), .flush_i(flush_i),
        .busy_o(busy_o), .stall_o(stall_o), .done_o(done_o),
        .hi_o(hi_o), .lo_o(lo_o), .div_zero_o(div_zero_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [1:0]  op;
        logic [31:0] a, b;
        logic [31:0] exp_hi, exp_lo;
        logic        exp_dz;
    } vec_t;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic run_op(input string name, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, output int lat, output int stl,
                          output logic [31:0] hi, output logic [31:0] lo, output logic dz);
        op_i = op; src1_i = a; src2_i = b; start_i = 1'b1;
        #1;
        stl = stall_o ? 1 : 0;
        tick();
        start_i = 1'b0;
        lat = 1;
        while (!done_o && lat < 100) begin
            if (stall_o) stl++;
            tick();
            lat++;
        end
        hi = hi_o; lo = lo_o; dz = div_zero_o;
        chk({name, " stall_in_done"}, {63'd0, stall_o}, 64'd0);
        tick();
        chk({name, " done_one_cycle"}, {63'd0, done_o}, 64'd0);
        chk({name, " idle_after_done"}, {63'd0, busy_o}, 64'd0);
    endtask

    vec_t        vecs[10];
    int          lat, stl, n, dones;
    logic [31:0] hi, lo, old_hi, old_lo;
    logic        dz;

    initial begin
        vecs[0] = '{"mult_neg3x5",   2'b00, 32'hFFFFFFFD, 32'd5,        32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0};
        vecs[1] = '{"multu_max",     2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0};
        vecs[2] = '{"div_wrap",      2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0};
        vecs[3] = '{"div_neg7_2",    2'b10, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
        vecs[4] = '{"divu_100_7",    2'b11, 32'd100,      32'd7,        32'd2,        32'd14,       1'b0};
        vecs[5] = '{"divu_by_zero",  2'b11, 32'd100,      32'd0,        32'h00000064, 32'hFFFFFFFF, 1'b1};
        vecs[6] = '{"div_neg_by_0",  2'b10, 32'hFFFFFF9C, 32'd0,        32'hFFFFFF9C, 32'hFFFFFFFF, 1'b1};
        vecs[7] = '{"div_7_neg2",    2'b10, 32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD, 1'b0};
        vecs[8] = '{"mult_min_sq",   2'b00, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0};
        vecs[9] = '{"multu_6x7",     2'b01, 32'd6,        32'd7,        32'd0,        32'd42,       1'b0};

        rst = 1'b1; start_i = 1'b0; flush_i = 1'b0; op_i = 2'b00; src1_i = '0; src2_i = '0;
        tick(); tick();
        chk("rst busy", {63'd0, busy_o}, 64'd0);
        chk("rst done", {63'd0, done_o}, 64'd0);
        chk("rst dz",   {63'd0, div_zero_o}, 64'd0);
        chk("rst hilo", {hi_o, lo_o}, 64'd0);
        rst = 1'b0;
        tick();

        foreach (vecs[i]) begin
            run_op(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, lat, stl, hi, lo, dz);
            chk({vecs[i].name, " hi"}, {32'd0, hi}, {32'd0, vecs[i].exp_hi});
            chk({vecs[i].name, " lo"}, {32'd0, lo}, {32'd0, vecs[i].exp_lo});
            chk({vecs[i].name, " dz"}, {63'd0, dz}, {63'd0, vecs[i].exp_dz});
            chk({vecs[i].name, " latency"}, 64'(lat), vecs[i].exp_dz ? 64'd1 : 64'd33);
            chk({vecs[i].name, " stall_cycles"}, 64'(stl), vecs[i].exp_dz ? 64'd1 : 64'd33);
        end

        // flush in the start cycle: request dropped
        op_i = 2'b00; src1_i = 32'd3; src2_i = 32'd3; start_i = 1'b1; flush_i = 1'b1;
        #1;
        chk("flush_start stall", {63'd0, stall_o}, 64'd0);
        tick();
        start_i = 1'b0; flush_i = 1'b0;
        chk("flush_start busy", {63'd0, busy_o}, 64'd0);

        // flush mid-divide at T+10
        old_hi = hi_o; old_lo = lo_o;
        op_i = 2'b10; src1_i = 32'd1000; src2_i = 32'd3; start_i = 1'b1;
        tick();
        start_i = 1'b0;
        for (int k = 0; k < 9; k++) tick();
        flush_i = 1'b1;
        #1;
        chk("flush done gated", {63'd0, done_o}, 64'd0);
        tick();
        flush_i = 1'b0;
        chk("flush busy", {63'd0, busy_o}, 64'd0);
        dones = 0;
        for (int k = 0; k < 40; k++) begin
            if (done_o) dones++;
            tick();
        end
        chk("flush no done", 64'(dones), 64'd0);
        chk("flush hilo kept", {hi_o, lo_o}, {old_hi, old_lo});
        run_op("after_flush", 2'b00, 32'd6, 32'd7, lat, stl, hi, lo, dz);
        chk("after_flush lo", {32'd0, lo}, 64'd42);
        chk("after_flush hi", {32'd0, hi}, 64'd0);

        // start_i during DONE is ignored
        op_i = 2'b01; src1_i = 32'd2; src2_i = 32'd2; start_i = 1'b1;
        tick();
        start_i = 1'b0;
        n = 1;
        while (!done_o && n < 100) begin tick(); n++; end
        start_i = 1'b1; src1_i = 32'd9;
        tick();
        start_i = 1'b0;
        chk("start_in_done busy", {63'd0, busy_o}, 64'd0);
        chk("start_in_done lo", {32'd0, lo_o}, 64'd4);

        // start while busy ignored
        op_i = 2'b01; src1_i = 32'd1000; src2_i = 32'd3; start_i = 1'b1;
        tick();
        start_i = 1'b0;
        for (int k = 0; k < 4; k++) tick();
        op_i = 2'b00; src1_i = 32'd7; src2_i = 32'd7; start_i = 1'b1;
        tick();
        start_i = 1'b0;
        n = 6;
        while (!done_o && n < 100) begin tick(); n++; end
        chk("busy_start latency", 64'(n), 64'd33);
        chk("busy_start lo", {32'd0, lo_o}, 64'd3000);
        chk("busy_start hi", {32'd0, hi_o}, 64'd0);
        tick();

        // async reset mid-operation at T+20
        op_i = 2'b11; src1_i = 32'd500; src2_i = 32'd7; start_i = 1'b1;
        tick();
        start_i = 1'b0;
        for (int k = 0; k < 19; k++) tick();
        rst = 1'b1;
        #1;
        chk("midrst busy", {63'd0, busy_o}, 64'd0);
        chk("midrst stall", {63'd0, stall_o}, 64'd0);
        chk("midrst done", {63'd0, done_o}, 64'd0);
        chk("midrst hilo", {hi_o, lo_o}, 64'd0);
        tick();
        rst = 1'b0;
        dones = 0;
        for (int k = 0; k < 40; k++) begin
            if (done_o) dones++;
            tick();
        end
        chk("midrst no done", 64'(dones), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
